crop_roi_stream: RTL and testbench

//  Multi-pixel-per-beat AXI4-Stream region-of-interest cropper; successor to the single-pixel fixed-window crop.

---
 rtl/crop_roi_stream_if.sv | 24 ++
 rtl/crop_roi_stream.sv | 217 +++++++++++++++++++++
 tb/tb_crop_roi_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crop_roi_stream_if.sv
// ---------------------------------------------------------------------------
// crop_roi_stream_if
//   AXI4-Stream bundle used on both sides of crop_roi_stream.
//   tvalid/tready : handshake
//   tdata         : DATA_W bits of packed pixels
//   tuser         : USER_W bits, bit0 = SOF, bit1 = EOL
//   tlast         : end of frame
//   master modport drives the payload, slave modport drives tready.
//   The instance widths must match the crop_roi_stream parameters
//   (DATA_W = PIXEL_BIT_WIDTH*PIXELS_PER_BEAT, USER_W = USER_WIDTH).
// ---------------------------------------------------------------------------
interface crop_roi_stream_if #(
  parameter int DATA_W = 40,
  parameter int USER_W = 2
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/crop_roi_stream.sv
// ---------------------------------------------------------------------------
// crop_roi_stream
//   Multi-pixel-per-beat AXI4-Stream region-of-interest cropper. Row/column
//   are tracked from tuser SOF/EOL, the window (in beats/rows) is latched on
//   the SOF beat, SOF/EOL/tlast are regenerated for the cropped frame and
//   ap_done pulses once the last cropped beat has left the output buffer.
// Ports
//   clk, srst          : clock, synchronous active-high reset
//   ap_start           : arm for one frame (only honoured in IDLE)
//   ap_done / ap_idle  : one-cycle frame-complete pulse / idle status
//   crop_x0, crop_w    : window left edge and width, in beats
//   crop_y0, crop_h    : window top row and height, in rows
//   s_axis (slave)     : input pixel stream (tlast input is not used)
//   m_axis (master)    : cropped pixel stream
//   cfg_err            : sticky invalid-window flag
// Build option
//   CROP_CFG_CHECK_EN  : when defined, a window that does not fit the frame
//                        (or has zero size) sets cfg_err and suppresses the
//                        whole frame's output. Undefined: no check, cfg_err=0.
// ---------------------------------------------------------------------------
module crop_roi_stream #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int PIXELS_PER_BEAT = 4,
  parameter int USER_WIDTH      = 2,
  parameter int IN_ROWS         = 1024,
  parameter int IN_COLS         = 1024,
  localparam int NB = IN_COLS / PIXELS_PER_BEAT,
  localparam int CB = $clog2(NB + 1),
  localparam int RB = $clog2(IN_ROWS + 1)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic [CB-1:0]          crop_x0,
  input  logic [CB-1:0]          crop_w,
  input  logic [RB-1:0]          crop_y0,
  input  logic [RB-1:0]          crop_h,
  crop_roi_stream_if.slave       s_axis,
  crop_roi_stream_if.master      m_axis,
  output logic                   cfg_err
);
  localparam int DATA_W  = PIXEL_BIT_WIDTH * PIXELS_PER_BEAT;
  localparam int ENTRY_W = DATA_W + USER_WIDTH + 1;
  localparam logic [CB-1:0] LAST_COL = CB'(NB - 1);
  localparam logic [RB-1:0] LAST_ROW = RB'(IN_ROWS - 1);
  localparam logic [CB:0]   ONE_X    = (CB+1)'(1);
  localparam logic [RB:0]   ONE_Y    = (RB+1)'(1);
`ifdef CROP_CFG_CHECK_EN
  localparam logic [CB:0]   NB_X     = (CB+1)'(NB);
  localparam logic [RB:0]   ROWS_X   = (RB+1)'(IN_ROWS);
`endif

  typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CB-1:0]        col_q, col_d;
  logic [RB-1:0]        row_q, row_d;
  logic [CB-1:0]        x0_q, x0_d, w_q, w_d;
  logic [RB-1:0]        y0_q, y0_d, h_q, h_d;
  logic                 bad_q, bad_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [ENTRY_W-1:0]   e0_q, e0_d, e1_q, e1_d;
  logic [1:0]           cnt_q, cnt_d;

  logic                 s_fire, sof_in, eol_in, arm_sof, proc, pop;
  logic [CB-1:0]        cur_col, wx0, ww;
  logic [RB-1:0]        cur_row, wy0, wh;
  logic [CB:0]          x_end;
  logic [RB:0]          y_end;
  logic                 bad_now, frame_bad, in_win, keep;
  logic                 o_sof, o_eol, o_last, row_clear, frame_end;
  logic [USER_WIDTH-1:0] o_user;
  logic [ENTRY_W-1:0]   entry_in;
  logic                 unused_s_tlast;

  assign unused_s_tlast  = s_axis.tlast;
  assign s_axis.tready   = (cnt_q != 2'd2);
  assign m_axis.tvalid   = (cnt_q != 2'd0);
  assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = e0_q;
  assign ap_done         = (state_q == DONE);
  assign ap_idle         = (state_q == IDLE);
  assign cfg_err         = cfg_err_q;

  always_comb begin
    s_fire  = s_axis.tvalid && s_axis.tready;
    sof_in  = s_axis.tuser[0];
    eol_in  = s_axis.tuser[1];
    arm_sof = (state_q == ARMED) && s_fire && sof_in;
    proc    = arm_sof || ((state_q == ACTIVE) && s_fire);
    pop     = m_axis.tvalid && m_axis.tready;

    // Any SOF (first one or a short-frame restart) is position (0,0).
    cur_row = sof_in ? '0 : row_q;
    cur_col = sof_in ? '0 : col_q;

    // The SOF beat in ARMED uses the live window; later beats the latched one.
    wx0 = (state_q == ARMED) ? crop_x0 : x0_q;
    ww  = (state_q == ARMED) ? crop_w  : w_q;
    wy0 = (state_q == ARMED) ? crop_y0 : y0_q;
    wh  = (state_q == ARMED) ? crop_h  : h_q;

    // One extra bit so x0+w / y0+h never wrap.
    x_end = {1'b0, wx0} + {1'b0, ww};
    y_end = {1'b0, wy0} + {1'b0, wh};

`ifdef CROP_CFG_CHECK_EN
    bad_now = (x_end > NB_X) || (y_end > ROWS_X) || (ww == '0) || (wh == '0);
`else
    bad_now = 1'b0;
`endif
    frame_bad = arm_sof ? bad_now : bad_q;

    in_win = (cur_row >= wy0) && ({1'b0, cur_row} < y_end) &&
             (cur_col >= wx0) && ({1'b0, cur_col} < x_end);
    keep   = proc && in_win && !frame_bad;

    o_sof  = (cur_row == wy0) && (cur_col == wx0);
    o_eol  = (({1'b0, cur_col} + ONE_X) == x_end);
    o_last = (({1'b0, cur_row} + ONE_Y) == y_end) && o_eol;
    o_user    = s_axis.tuser;
    o_user[0] = o_sof;
    o_user[1] = o_eol;
    entry_in  = {s_axis.tdata, o_user, o_last};

    row_clear = eol_in || (cur_col == LAST_COL);
    frame_end = proc && row_clear && (cur_row == LAST_ROW);

    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x0_d      = x0_q;
    w_d       = w_q;
    y0_d      = y0_q;
    h_d       = h_q;
    bad_d     = bad_q;
    cfg_err_d = cfg_err_q | (arm_sof & bad_now);
    e0_d      = e0_q;
    e1_d      = e1_q;
    cnt_d     = cnt_q;

    if (proc) begin
      if (row_clear) begin
        col_d = '0;
        row_d = cur_row + RB'(1);
      end else begin
        col_d = cur_col + CB'(1);
        row_d = cur_row;
      end
    end

    case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (ap_start) state_d = ARMED;
      end
      ARMED: begin
        if (arm_sof) begin
          x0_d    = crop_x0;
          w_d     = crop_w;
          y0_d    = crop_y0;
          h_d     = crop_h;
          bad_d   = bad_now;
          state_d = frame_end ? DRAIN : ACTIVE;
        end
      end
      ACTIVE:  if (frame_end) state_d = DRAIN;
      DRAIN:   if (cnt_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Two-entry skid buffer; e0 is always the head presented on m_axis.
    case (cnt_q)
      2'd0: if (keep) begin e0_d = entry_in; cnt_d = 2'd1; end
      2'd1: begin
        if (keep && pop)   e0_d = entry_in;
        else if (keep) begin e1_d = entry_in; cnt_d = 2'd2; end
        else if (pop)      cnt_d = 2'd0;
      end
      2'd2: if (pop) begin e0_d = e1_q; cnt_d = 2'd1; end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      x0_q      <= '0;
      w_q       <= '0;
      y0_q      <= '0;
      h_q       <= '0;
      bad_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      e0_q      <= '0;
      e1_q      <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x0_q      <= x0_d;
      w_q       <= w_d;
      y0_q      <= y0_d;
      h_q       <= h_d;
      bad_q     <= bad_d;
      cfg_err_q <= cfg_err_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_crop_roi_stream.sv
// ---------------------------------------------------------------------------
// tb_crop_roi_stream
//   Randomized scoreboard bench for crop_roi_stream on an 8x8 frame with
//   4 pixels per beat (2 beats per row). The driver pushes the expected
//   cropped beats into a queue as each input beat is accepted; a monitor
//   pops and compares whenever an output beat is transferred.
// ---------------------------------------------------------------------------
module tb_crop_roi_stream;
  localparam int PBW  = 10;
  localparam int PPB  = 4;
  localparam int UW   = 2;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int NB   = COLS / PPB;
  localparam int CB   = $clog2(NB + 1);
  localparam int RB   = $clog2(ROWS + 1);
  localparam int DW   = PBW * PPB;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int x0;
    int w;
    int y0;
    int h;
  } win_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          cfg_err;
  logic [CB-1:0] crop_x0, crop_w;
  logic [RB-1:0] crop_y0, crop_h;

  crop_roi_stream_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  crop_roi_stream_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  crop_roi_stream #(
    .PIXEL_BIT_WIDTH(PBW), .PIXELS_PER_BEAT(PPB), .USER_WIDTH(UW),
    .IN_ROWS(ROWS), .IN_COLS(COLS)
  ) dut (
    .clk(clk), .srst(srst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .crop_x0(crop_x0), .crop_w(crop_w), .crop_y0(crop_y0), .crop_h(crop_h),
    .s_axis(s_if), .m_axis(m_if), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    out_beats = 0;
  int    done_cnt = 0;
  int    last_cyc = 0;
  int    done_cyc = 0;
  bit    abort = 0;
  bit    rdy_rand = 0;
  bit    gaps = 0;
  beat_t exp_q[$];
  beat_t held, cur, ex;
  bit    hold_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Output ready: always 1, or a fresh random value each cycle.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (srst) begin
      hold_v = 0;
    end else begin
      cur = {m_if.tdata, m_if.tuser, m_if.tlast};
      if (hold_v) begin
        if (!m_if.tvalid) chk("stall_valid_held", 64'(m_if.tvalid), 64'd1);
        else              chk("stall_payload_stable", 64'(cur), 64'(held));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got=%0h expected=none (cycle %0d)", cur, cyc);
        end else begin
          ex = exp_q.pop_front();
          chk("out_tdata", 64'(cur.d), 64'(ex.d));
          chk("out_tuser", 64'(cur.u), 64'(ex.u));
          chk("out_tlast", 64'(cur.l), 64'(ex.l));
        end
        out_beats++;
        if (m_if.tlast) last_cyc = cyc;
        hold_v = 0;
      end else if (m_if.tvalid) begin
        hold_v = 1;
        held   = cur;
      end else begin
        hold_v = 0;
      end
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic bit in_win(input int r, input int c, input win_t win);
    return (r >= win.y0) && (r < win.y0 + win.h) && (c >= win.x0) && (c < win.x0 + win.w);
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, output bit acc);
    int n;
    acc = 0;
    n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    forever begin
      @(negedge clk);
      if (abort) begin
        s_if.tvalid = 1'b0;
        return;
      end
      if (s_if.tready) break;
      n++;
      if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL input_accept_timeout got=stalled expected=tready (cycle %0d)", cyc);
        s_if.tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    acc = 1;
  endtask

  task automatic arm(input win_t win);
    bit acc;
    crop_x0  = CB'(win.x0);
    crop_w   = CB'(win.w);
    crop_y0  = RB'(win.y0);
    crop_h   = RB'(win.h);
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    // Stray beats before SOF must be discarded.
    for (int i = 0; i < 2; i++) drive_beat(DW'({$urandom(), $urandom()}), UW'(2 * i), acc);
  endtask

  task automatic send_rows(input int rows, input win_t win, input bit bad, input int chg_at);
    bit            acc;
    beat_t         e;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          s_if.tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
        d    = DW'({$urandom(), $urandom()});
        u    = '0;
        u[0] = (r == 0) && (c == 0);
        u[1] = (c == NB - 1);
        drive_beat(d, u, acc);
        if (!acc) return;
        if (!bad && in_win(r, c, win)) begin
          e.d    = d;
          e.u    = '0;
          e.u[0] = (r == win.y0) && (c == win.x0);
          e.u[1] = (c == win.x0 + win.w - 1);
          e.l    = (r == win.y0 + win.h - 1) && (c == win.x0 + win.w - 1);
          exp_q.push_back(e);
        end
        if (r * NB + c == chg_at) crop_x0 = CB'($urandom_range(0, NB - 1));
      end
    end
  endtask

  task automatic wait_done(input int base_done);
    int n;
    n = 0;
    while (done_cnt == base_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("ap_done_pulses", 64'(done_cnt - base_done), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("ap_idle_after_done", 64'(ap_idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input win_t win, input bit bad, input int chg_at);
    int bd;
    bd = done_cnt;
    arm(win);
    send_rows(ROWS, win, bad, chg_at);
    wait_done(bd);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=running expected=finished (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    win_t win;
    int   base;
    int   n;
    srst = 1'b1;
    ap_start = 1'b0;
    crop_x0 = '0; crop_w = '0; crop_y0 = '0; crop_h = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_m_tuser", 64'(m_if.tuser), 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_ap_done", 64'(ap_done), 64'd0);
    chk("rst_ap_idle", 64'(ap_idle), 64'd1);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    srst = 1'b0;
    @(posedge clk);
    #1;

    // Full-width window: byte-identical pass-through, done 2 cycles after tlast.
    win = '{x0: 0, w: 2, y0: 0, h: 8};
    base = out_beats;
    run_frame(win, 1'b0, -1);
    chk("full_beat_count", 64'(out_beats - base), 64'd16);
    chk("done_after_tlast", 64'(done_cyc - last_cyc), 64'd2);

    // Small window, ready held high.
    win = '{x0: 1, w: 1, y0: 3, h: 2};
    base = out_beats;
    run_frame(win, 1'b0, -1);
    chk("small_beat_count", 64'(out_beats - base), 64'd2);

    // Same window with random backpressure and input gaps.
    rdy_rand = 1;
    gaps = 1;
    base = out_beats;
    run_frame(win, 1'b0, -1);
    chk("stall_beat_count", 64'(out_beats - base), 64'd2);

    // Random windows, crop_x0 changed mid-frame.
    for (int f = 0; f < 5; f++) begin
      win.x0 = $urandom_range(0, NB - 1);
      win.w  = $urandom_range(1, NB - win.x0);
      win.y0 = $urandom_range(0, ROWS - 1);
      win.h  = $urandom_range(1, ROWS - win.y0);
      run_frame(win, 1'b0, $urandom_range(0, ROWS * NB - 1));
    end

    // Short frame: a new SOF restarts the counters with the same window.
    win = '{x0: 1, w: 1, y0: 1, h: 3};
    base = done_cnt;
    arm(win);
    send_rows(3, win, 1'b0, -1);
    send_rows(ROWS, win, 1'b0, -1);
    wait_done(base);

    // Reset at the fifth output beat, then a fresh frame.
    rdy_rand = 0;
    gaps = 0;
    win = '{x0: 0, w: 2, y0: 0, h: 8};
    base = out_beats;
    fork
      begin
        arm(win);
        send_rows(ROWS, win, 1'b0, -1);
      end
      begin
        n = 0;
        while (out_beats < base + 5 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        srst = 1'b1;
        abort = 1;
        @(posedge clk);
        #2;
        exp_q.delete();
        @(negedge clk);
        chk("srst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("srst_m_tdata", 64'(m_if.tdata), 64'd0);
        chk("srst_m_tuser", 64'(m_if.tuser), 64'd0);
        chk("srst_m_tlast", 64'(m_if.tlast), 64'd0);
        chk("srst_ap_done", 64'(ap_done), 64'd0);
        chk("srst_ap_idle", 64'(ap_idle), 64'd1);
        srst = 1'b0;
      end
    join
    abort = 0;
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    win = '{x0: 1, w: 1, y0: 3, h: 2};
    base = out_beats;
    rdy_rand = 1;
    run_frame(win, 1'b0, -1);
    chk("post_srst_beat_count", 64'(out_beats - base), 64'd2);

`ifdef CROP_CFG_CHECK_EN
    // Window runs past the bottom: no output, sticky error, ap_done once.
    win = '{x0: 0, w: 2, y0: 6, h: 4};
    base = out_beats;
    run_frame(win, 1'b1, -1);
    chk("cfg_err_set", 64'(cfg_err), 64'd1);
    chk("cfg_bad_beat_count", 64'(out_beats - base), 64'd0);
`else
    chk("cfg_err_tied_low", 64'(cfg_err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
